phy_rx_serial_align: RTL and testbench

- Receive-side serial-to-parallel stage that sits directly downstream of the physical-layer transmitter and consumes its 1-bit serial output.
- Hunts for the COM symbol (8'hBC) at any bit offset, then locks byte alignment after COM_COUNT consecutive aligned COMs.
- Once locked, delivers recovered bytes with a valid strobe to the receive demux; COM bytes act as idle and are dropped.

---
 rtl/phy_pkg.sv | 16 +
 rtl/phy_rx_lock_fsm.sv | 83 ++++++++
 rtl/phy_rx_serial_align.sv | 49 ++++
 tb/tb_phy_rx_serial_align.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared constants and state encoding for the serial receive alignment path.
package phy_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned COM_CNT_W = 4;

    localparam logic [BYTE_W-1:0] COM = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/phy_rx_lock_fsm.sv
// Byte-alignment FSM: hunts for COM at any bit offset, then confirms
// COM_COUNT aligned COMs before declaring the lane active.
import phy_pkg::*;

module phy_rx_lock_fsm #(
    parameter int unsigned COM_COUNT = 4
) (
    input  logic clk32f,
    input  logic reset,
    input  logic sr_is_com,
    output logic active,
    output logic boundary_active
);

    rx_state_e              state;
    rx_state_e              state_nxt;
    logic [COM_CNT_W-1:0]   com_cnt;
    logic [COM_CNT_W-1:0]   com_cnt_nxt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
    logic                   boundary;
    logic                   active_nxt;

    assign boundary = (bit_cnt == BIT_CNT_W'(7));

    // State register
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state   <= SEARCH;
            com_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            com_cnt <= com_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            active  <= active_nxt;
        end
    end

    // Next-state logic; a COM hit in SEARCH restarts bit_cnt so the next
    // boundary lands exactly one byte after the match.
    always_comb begin
        state_nxt   = state;
        com_cnt_nxt = com_cnt;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        case (state)
            SEARCH: begin
                if (sr_is_com) begin
                    bit_cnt_nxt = '0;
                    com_cnt_nxt = COM_CNT_W'(1);
                    state_nxt   = (COM_COUNT == 1) ? ACTIVE : LOCK;
                end
            end
            LOCK: begin
                if (boundary) begin
                    if (sr_is_com) begin
                        com_cnt_nxt = com_cnt + COM_CNT_W'(1);
                        if (com_cnt_nxt == COM_CNT_W'(COM_COUNT)) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        com_cnt_nxt = '0;
                        state_nxt   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
            end
            default: begin
                state_nxt   = SEARCH;
                com_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs; boundary_active is a decode of registered state only
    always_comb begin
        active_nxt      = (state_nxt == ACTIVE);
        boundary_active = (state == ACTIVE) && boundary;
    end

endmodule

// File: rtl/phy_rx_serial_align.sv
// Serial-to-parallel receive stage: aligns on COM and delivers non-COM bytes
// with a one-cycle valid strobe.
import phy_pkg::*;

module phy_rx_serial_align #(
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    logic [BYTE_W-1:0] sr;
    logic              sr_is_com;
    logic              boundary_active;

    assign sr_is_com = (sr == COM);

    phy_rx_lock_fsm #(
        .COM_COUNT(COM_COUNT)
    ) u_lock_fsm (
        .clk32f         (clk32f),
        .reset          (reset),
        .sr_is_com      (sr_is_com),
        .active         (active),
        .boundary_active(boundary_active)
    );

    // Shift in MSB-first; COM bytes seen while active are idle and dropped
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            sr        <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            sr <= {sr[BYTE_W-2:0], data_in};
            if (boundary_active && !sr_is_com) begin
                data_out  <= sr;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_serial_align.sv
// Directed bench for phy_rx_serial_align: reset, lock, offset lock, lock
// failure, idle handling and an end-to-end lane stream.
module tb_phy_rx_serial_align;

    logic       clk32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int         checks;
    int         errors;
    int         cyc;
    int         last_cyc;
    logic [7:0] got_q[$];
    int         got_cyc[$];

    phy_rx_serial_align dut (
        .clk32f   (clk32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    initial clk32f = 1'b0;
    always #5 clk32f = ~clk32f;

    initial cyc = 0;
    always @(posedge clk32f) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit for one edge and log any strobe seen just after that edge
    task automatic bit_tick(input logic b);
        @(negedge clk32f);
        data_in = b;
        @(posedge clk32f);
        #1;
        if (valid_out) begin
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_tick(v[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk32f);
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (2) @(negedge clk32f);
        reset = 1'b1;
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        data_in = 1'b0;

        // Reset held with random serial data
        for (int i = 0; i < 6; i++) begin
            @(negedge clk32f);
            data_in = 1'($urandom);
            @(posedge clk32f);
            #1;
            check("rst_out", {23'd0, data_out, valid_out}, 32'd0);
            check("rst_act", {31'd0, active}, 32'd0);
        end
        @(negedge clk32f);
        reset = 1'b1;

        // Clean lock from bit 0
        repeat (3) send_bits(8'hBC, 8);
        check("clean_act_3com", {31'd0, active}, 32'd0);
        send_bits(8'hBC, 8);
        check("clean_act_32nd_bit", {31'd0, active}, 32'd0);
        check("clean_no_valid_lock", got_q.size(), 32'd0);
        send_bits(8'h00, 1);
        check("clean_act_rise", {31'd0, active}, 32'd1);
        send_bits(8'h5A, 7);
        last_cyc = cyc;
        send_bits(8'hBC, 8);
        check("clean_cnt", got_q.size(), 32'd1);
        check("clean_data", {24'd0, got_q[0]}, 32'h5A);
        check("clean_latency", got_cyc[0], last_cyc + 1);
        check("clean_hold", {24'd0, data_out}, 32'h5A);
        check("clean_valid_low", {31'd0, valid_out}, 32'd0);

        // Reset asserted mid-byte clears outputs before the next edge
        send_bits(8'h05, 3);
        @(negedge clk32f);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_data", {24'd0, data_out}, 32'd0);
        check("midrst_valid", {31'd0, valid_out}, 32'd0);
        check("midrst_act", {31'd0, active}, 32'd0);
        @(negedge clk32f);
        reset = 1'b1;
        got_q.delete();
        got_cyc.delete();

        // Offset lock after three junk bits
        send_bits(8'h05, 3);
        repeat (3) send_bits(8'hBC, 8);
        check("off_act_pre", {31'd0, active}, 32'd0);
        send_bits(8'hBC, 8);
        send_bits(8'hA5, 8);
        check("off_act", {31'd0, active}, 32'd1);
        send_bits(8'hBC, 8);
        check("off_cnt", got_q.size(), 32'd1);
        check("off_data", {24'd0, got_q[0]}, 32'hA5);

        // Lock failure, then re-lock
        do_reset();
        send_bits(8'hBC, 8);
        check("fail_act_b1", {31'd0, active}, 32'd0);
        send_bits(8'hBC, 8);
        check("fail_act_b2", {31'd0, active}, 32'd0);
        send_bits(8'h00, 8);
        check("fail_act_b3", {31'd0, active}, 32'd0);
        repeat (4) send_bits(8'hBC, 8);
        check("fail_no_valid", got_q.size(), 32'd0);
        send_bits(8'h3C, 8);
        check("fail_act_relock", {31'd0, active}, 32'd1);
        send_bits(8'hBC, 8);
        check("fail_cnt", got_q.size(), 32'd1);
        check("fail_data", {24'd0, got_q[0]}, 32'h3C);

        // Idle COMs while active are dropped
        got_q.delete();
        got_cyc.delete();
        send_bits(8'h11, 8);
        send_bits(8'hBC, 8);
        check("idle_hold1", {24'd0, data_out}, 32'h11);
        send_bits(8'hBC, 8);
        check("idle_hold2", {24'd0, data_out}, 32'h11);
        check("idle_valid_low", {31'd0, valid_out}, 32'd0);
        send_bits(8'h22, 8);
        send_bits(8'hBC, 8);
        check("idle_cnt", got_q.size(), 32'd2);
        check("idle_d0", {24'd0, got_q[0]}, 32'h11);
        check("idle_d1", {24'd0, got_q[1]}, 32'h22);
        check("idle_gap", got_cyc[1] - got_cyc[0], 32'd24);

        // End-to-end lane stream after a COM preamble
        do_reset();
        repeat (4) send_bits(8'hBC, 8);
        send_bits(8'hFF, 8);
        send_bits(8'hEE, 8);
        send_bits(8'hDD, 8);
        send_bits(8'hCC, 8);
        send_bits(8'hBC, 8);
        check("e2e_act", {31'd0, active}, 32'd1);
        check("e2e_cnt", got_q.size(), 32'd4);
        check("e2e_d0", {24'd0, got_q[0]}, 32'hFF);
        check("e2e_d1", {24'd0, got_q[1]}, 32'hEE);
        check("e2e_d2", {24'd0, got_q[2]}, 32'hDD);
        check("e2e_d3", {24'd0, got_q[3]}, 32'hCC);
        check("e2e_gap", got_cyc[3] - got_cyc[0], 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
